ch_nibble_packer: RTL and testbench

- Downstream stage of the ch_queue dequeue port.
- Accepts DATA_WIDTH-bit items over a valid/ready handshake and packs PACK consecutive items into one wide word.
- Presents the packed word on a registered valid/ready output toward the wide datapath.
- Sustains one input item per cycle, including across word boundaries.

---
 rtl/ch_packer_pkg.sv | 10 +
 rtl/ch_nibble_packer.sv | 79 +++++++
 tb/tb_ch_nibble_packer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ch_packer_pkg.sv
// ch_packer_pkg: shared state encoding, count width and lane indexing for ch_nibble_packer
package ch_packer_pkg;
  typedef enum logic {FILL, HOLD} state_t;
  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction
  function automatic int lane_lo(input int idx, input int dw);
    return idx * dw;
  endfunction
endpackage

// File: rtl/ch_nibble_packer.sv
// ch_nibble_packer: packs PACK items into one registered wide word; PACKER_FLUSH_EN adds io_flush for partial words
module ch_nibble_packer
  import ch_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int PACK = 4,
  parameter int CNT_W = cnt_width(PACK)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_in_valid,
  input  logic [DATA_WIDTH-1:0]      io_in_data,
  output logic                       io_in_ready,
  output logic                       io_out_valid,
  output logic [DATA_WIDTH*PACK-1:0] io_out_data,
  input  logic                       io_out_ready,
  output logic [CNT_W-1:0]           io_out_count
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                       io_flush
`endif
);
  state_t state, state_nx;
  logic [DATA_WIDTH*PACK-1:0] lanes, lanes_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, out_count, count_nx, post_cnt;
  logic in_fire, out_fire, last, flush_go;
  assign in_fire  = io_in_valid & io_in_ready;
  assign out_fire = io_out_valid & io_out_ready;
  assign post_cnt = cnt + CNT_W'(in_fire);
  assign last     = in_fire && cnt == CNT_W'(PACK - 1);
`ifdef PACKER_FLUSH_EN
  assign flush_go = io_flush && state == FILL && post_cnt != '0;
`else
  assign flush_go = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      cnt       <= '0;
      lanes     <= '0;
      out_count <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lanes     <= lanes_nx;
      out_count <= count_nx;
    end
  end
  always_comb begin
    state_nx = state == FILL ? ((last || flush_go) ? HOLD : FILL) : (out_fire ? FILL : HOLD);
  end
  // A word leaving in the same cycle as a new item arrives restarts with that item in lane 0.
  always_comb begin
    lanes_nx = lanes;
    cnt_nx   = cnt;
    count_nx = out_count;
    if (state == HOLD) begin
      if (out_fire) begin
        lanes_nx = '0;
        cnt_nx   = '0;
        count_nx = '0;
        if (in_fire) begin
          lanes_nx[DATA_WIDTH-1:0] = io_in_data;
          cnt_nx = CNT_W'(1);
        end
      end
    end else begin
      if (in_fire) lanes_nx[lane_lo(int'(cnt), DATA_WIDTH) +: DATA_WIDTH] = io_in_data;
      cnt_nx   = (last || flush_go) ? '0 : post_cnt;
      count_nx = (last || flush_go) ? post_cnt : out_count;
    end
  end
  always_comb begin
    io_out_valid = state == HOLD;
    io_in_ready  = !reset && (state == FILL || io_out_ready);
    io_out_data  = lanes;
    io_out_count = out_count;
  end
endmodule

// File: tb/tb_ch_nibble_packer.sv
// tb_ch_nibble_packer: scoreboard bench with a queue-based packing model; define PACKER_FLUSH_EN to cover io_flush
module tb_ch_nibble_packer;
  localparam int DW = 4, P = 4, OW = DW * P, CW = $clog2(P + 1);
  typedef struct {logic [OW-1:0] d; logic [CW-1:0] c;} exp_t;
  logic clk = 0, reset = 1, io_in_valid = 0, io_out_ready = 0, io_flush = 0;
  logic [DW-1:0] io_in_data = 0;
  logic io_in_ready, io_out_valid;
  logic [OW-1:0] io_out_data;
  logic [CW-1:0] io_out_count;
  int tests = 0, fails = 0, outstanding = 0;
  exp_t sb[$];
  logic [DW-1:0] cur[$];
  always #5 clk = ~clk;
  ch_nibble_packer #(.DATA_WIDTH(DW), .PACK(P)) dut (
    .clk(clk), .reset(reset), .io_in_valid(io_in_valid), .io_in_data(io_in_data),
    .io_in_ready(io_in_ready), .io_out_valid(io_out_valid), .io_out_data(io_out_data),
    .io_out_ready(io_out_ready), .io_out_count(io_out_count)
`ifdef PACKER_FLUSH_EN
    , .io_flush(io_flush)
`endif
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    io_in_valid = v;
    io_in_data = d;
    io_out_ready = r;
    io_flush = f;
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_out_valid", io_out_valid, 0);
    chk("async_out_data", io_out_data, 0);
    chk("async_in_ready", io_in_ready, 0);
    io_in_valid = 0;
    @(posedge clk);
    #1 reset = 0;
  endtask
  // Model: items accumulate in cur; a full (or flushed) word becomes an expected output.
  always @(negedge clk) begin
    logic pending, flush_now;
    logic [OW-1:0] w;
    if (reset) begin
      cur.delete();
      sb.delete();
      outstanding = 0;
      chk("rst_out_valid", io_out_valid, 0);
      chk("rst_in_ready", io_in_ready, 0);
    end else begin
      pending = outstanding > 0;
      chk("out_valid", io_out_valid, pending);
      chk("in_ready", io_in_ready, !pending || io_out_ready);
      if (pending && io_out_ready) outstanding--;
      if (io_in_valid && (!pending || io_out_ready)) cur.push_back(io_in_data);
      flush_now = 0;
`ifdef PACKER_FLUSH_EN
      flush_now = io_flush && !pending && cur.size() > 0;
`endif
      if (cur.size() == P || flush_now) begin
        w = '0;
        foreach (cur[i]) w[i*DW +: DW] = cur[i];
        sb.push_back('{w, CW'(cur.size())});
        cur.delete();
        outstanding++;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!reset && io_out_valid && io_out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word actual=%0h required=none", io_out_data);
      end else begin
        e = sb.pop_front();
        chk("word_data", io_out_data, e.d);
        chk("word_count", io_out_count, e.c);
      end
    end
  end
  initial begin
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1 reset = 0;
    for (int i = 1; i <= 4; i++) drive(1, DW'(i), 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) drive(1, DW'(i), 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) drive(1, DW'(i), 1, 0);
    repeat (3) drive(1, 4'h9, 0, 0);
    drive(1, 4'h9, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 4'hA, 1, 0);
    drive(1, 4'hB, 1, 0);
    pulse_reset();
    for (int i = 1; i <= 4; i++) drive(1, DW'(i), 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
`ifdef PACKER_FLUSH_EN
    drive(1, 4'h5, 1, 0);
    drive(1, 4'h6, 1, 0);
    drive(1, 4'h7, 1, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
`endif
    for (int i = 0; i < 800; i++) begin
      if (i == 400) pulse_reset();
      drive($urandom % 4 != 0, DW'($urandom), $urandom % 3 != 0, $urandom % 8 == 0);
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d pending words required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
